fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instr} pairs between fetch and decode/rename.
// Valid/ready on both sides; a synchronous flush discards every queued entry.
module fetch_queue #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [ADDR_WIDTH-1:0]  enq_pc,
  input  logic [INSTR_WIDTH-1:0] enq_instr,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [ADDR_WIDTH-1:0]  deq_pc,
  output logic [INSTR_WIDTH-1:0] deq_instr,
  output logic [CNT_WIDTH-1:0]   count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  enq_fire, deq_fire;

  // Handshake status comes only from state, so there is no enq-to-deq path.
  assign enq_ready = (count_q != CNT_WIDTH'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign deq_pc    = mem_q[rd_ptr_q].pc;
  assign deq_instr = mem_q[rd_ptr_q].instr;
  assign count     = count_q;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; flops below use only '<='.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        mem_d[wr_ptr_q] = '{pc: enq_pc, instr: enq_instr};
        wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the entry array is reset as well, because deq_pc/deq_instr must
  // read as zero after reset before anything has been written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed test-plan scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int AW    = 12;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  logic [AW-1:0] enq_pc;
  logic [IW-1:0] enq_instr;
  logic          deq_valid;
  logic          deq_ready;
  logic [AW-1:0] deq_pc;
  logic [IW-1:0] deq_instr;
  logic [CW-1:0] count;

  fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  ent_t          model_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          last_enq_fire;
  logic [AW-1:0] pc_next;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output against the reference queue.
  task automatic check_model(input string tag);
    int sz = model_q.size();
    check({tag, ".count"}, 64'(count), 64'(sz));
    check({tag, ".enq_ready"}, 64'(enq_ready), 64'(sz != DEPTH));
    check({tag, ".deq_valid"}, 64'(deq_valid), 64'(sz != 0));
    if (sz != 0) begin
      check({tag, ".deq_pc"}, 64'(deq_pc), 64'(model_q[0].pc));
      check({tag, ".deq_instr"}, 64'(deq_instr), 64'(model_q[0].instr));
    end
  endtask

  // One clock: decide what fires from the model's state, advance the model at
  // the edge, then check outputs 1 time unit later.
  task automatic step(input string tag);
    int   sz = model_q.size();
    logic ef = enq_valid && (sz != DEPTH) && !flush;
    logic df = deq_ready && (sz != 0) && !flush;
    ent_t e;
    e.pc    = enq_pc;
    e.instr = enq_instr;
    @(posedge clk);
    if (flush) model_q.delete();
    else begin
      if (df) void'(model_q.pop_front());
      if (ef) model_q.push_back(e);
    end
    last_enq_fire = ef;
    #1;
    check_model(tag);
  endtask

  task automatic set_in(input logic ev, input logic dr, input logic fl,
                        input logic [AW-1:0] pc, input logic [IW-1:0] ins);
    enq_valid = ev;
    deq_ready = dr;
    flush     = fl;
    enq_pc    = pc;
    enq_instr = ins;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, '0, '0);
    #2;
    check("rst.count", 64'(count), 64'd0);
    check("rst.enq_ready", 64'(enq_ready), 64'd1);
    check("rst.deq_valid", 64'(deq_valid), 64'd0);
    check("rst.deq_pc", 64'(deq_pc), 64'd0);
    check("rst.deq_instr", 64'(deq_instr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset: nothing changes, head reads stay zero.
    for (int i = 0; i < 3; i++) begin
      step("idle");
      check("idle.deq_pc", 64'(deq_pc), 64'd0);
      check("idle.deq_instr", 64'(deq_instr), 64'd0);
    end

    // Fill to DEPTH with the consumer stalled, then try one more.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b0, 1'b0, AW'(4 * i), IW'(32'hA0 + i));
      step("fill");
      check("fill.count", 64'(count), 64'(i + 1));
    end
    check("full.enq_ready", 64'(enq_ready), 64'd0);
    set_in(1'b1, 1'b0, 1'b0, 12'h010, 32'hA4);
    step("overfill");
    check("overfill.count", 64'(count), 64'd4);
    check("overfill.head_pc", 64'(deq_pc), 64'h000);
    check("overfill.head_instr", 64'(deq_instr), 64'hA0);

    // Drain in order.
    set_in(1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.pc", 64'(deq_pc), 64'(4 * i));
      check("drain.instr", 64'(deq_instr), 64'(32'hA0 + i));
      step("drain");
    end
    check("drain.deq_valid", 64'(deq_valid), 64'd0);
    check("drain.count", 64'(count), 64'd0);

    // Two entries in flight, then enq+deq every cycle across pointer wrap.
    pc_next = 12'h100;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b0, pc_next, {20'h0, pc_next});
      step("wrap.pre");
      pc_next += 12'd4;
    end
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b1, 1'b0, pc_next, {20'h0, pc_next});
      check("wrap.seq_pc", 64'(deq_pc), 64'(12'h100 + 12'(4 * i)));
      step("wrap");
      check("wrap.count", 64'(count), 64'd2);
      pc_next += 12'd4;
    end

    // Full with simultaneous enq+deq: only the dequeue fires.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b0, pc_next, 32'hBEEF);
      step("refill");
      pc_next += 12'd4;
    end
    check("full2.count", 64'(count), 64'd4);
    set_in(1'b1, 1'b1, 1'b0, 12'hFF0, 32'hDEAD);
    step("full_simul");
    check("full_simul.count", 64'(count), 64'd3);
    check("full_simul.enq_ready", 64'(enq_ready), 64'd1);

    // Flush with enq and deq both presented.
    set_in(1'b1, 1'b1, 1'b1, 12'hABC, 32'hCAFE);
    step("flush");
    check("flush.count", 64'(count), 64'd0);
    check("flush.deq_valid", 64'(deq_valid), 64'd0);
    set_in(1'b0, 1'b0, 1'b0, '0, '0);
    step("post_flush");

    // Asynchronous reset pulse between edges with two entries queued.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 12'h200 + 12'(4 * i), 32'h55);
      step("prereset");
    end
    set_in(1'b0, 1'b0, 1'b0, '0, '0);
    #2;
    reset_n = 1'b0;
    #1;
    model_q.delete();
    check("areset.count", 64'(count), 64'd0);
    check("areset.deq_valid", 64'(deq_valid), 64'd0);
    check("areset.enq_ready", 64'(enq_ready), 64'd1);
    check("areset.deq_pc", 64'(deq_pc), 64'd0);
    check("areset.deq_instr", 64'(deq_instr), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic with occasional flush.
    pc_next = 12'h000;
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 31) == 0), pc_next, $urandom);
      step("rand");
      if (last_enq_fire) pc_next += 12'd4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
